// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Source side of the reset bridges. Merges external, software, watchdog and
// PLL-loss reset events, holds every domain in reset until the PLL has been
// locked for a minimum time, then releases interconnect, peripherals and core
// in that order. Also reports busy status and a one-hot reset cause.
//
// Ports
//   i_aclk             in   system clock
//   i_reset            in   asynchronous, active-high reset
//   i_pll_locked       in   PLL lock (asynchronous, synchronized here)
//   i_sw_reset_req     in   software reset request (i_aclk domain)
//   i_wdt_expire       in   watchdog expiry (i_aclk domain)
//   o_ic_areset_n      out  interconnect reset, active-low
//   o_periph_areset_n  out  peripheral reset, active-low
//   o_core_reset       out  core reset, active-high
//   o_busy             out  high while any domain is held in reset
//   o_reset_cause      out  one-hot cause: [0] ext, [1] sw, [2] wdt, [3] pll loss
//
// State table
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   HOLD        | all resets asserted; counting lock-qualified cycles
//   REL_IC      | interconnect released; waiting one stage gap
//   REL_PERIPH  | peripherals released; waiting one stage gap
//   RUN         | all domains out of reset; watching for re-entry triggers
// -----------------------------------------------------------------------------
module reset_sequencer #(
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 8,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_aclk,
    input  logic       i_reset,
    input  logic       i_pll_locked,
    input  logic       i_sw_reset_req,
    input  logic       i_wdt_expire,
    output logic       o_ic_areset_n,
    output logic       o_periph_areset_n,
    output logic       o_core_reset,
    output logic       o_busy,
    output logic [3:0] o_reset_cause
);

    typedef enum logic [1:0] {
        ST_HOLD       = 2'd0,
        ST_REL_IC     = 2'd1,
        ST_REL_PERIPH = 2'd2,
        ST_RUN        = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

    localparam logic [3:0] CAUSE_EXT = 4'b0001;
    localparam logic [3:0] CAUSE_SW  = 4'b0010;
    localparam logic [3:0] CAUSE_WDT = 4'b0100;
    localparam logic [3:0] CAUSE_PLL = 4'b1000;

    // ------------------------------------------------------------------
    // Synchronizers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] rst_sync_q, rst_sync_d;
    logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
    logic                   rst_s;
    logic                   lock_s;

    // Reset chain fills with ones asynchronously and drains one zero per
    // edge, so the FSM stays parked until SYNC_STAGES edges after release.
    always_comb begin
        rst_sync_d  = {rst_sync_q[SYNC_STAGES-2:0], 1'b0};
        lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], i_pll_locked};
    end

    always_ff @(posedge i_aclk or posedge i_reset) begin
        if (i_reset) begin
            rst_sync_q  <= '1;
            lock_sync_q <= '0;
        end else begin
            rst_sync_q  <= rst_sync_d;
            lock_sync_q <= lock_sync_d;
        end
    end

    assign rst_s  = rst_sync_q[SYNC_STAGES-1];
    assign lock_s = lock_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cause_q, cause_d;
    logic             ic_areset_n_q, ic_areset_n_d;
    logic             periph_areset_n_q, periph_areset_n_d;
    logic             core_reset_q, core_reset_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;

        if (rst_s) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    // Lock loss here only restarts the qualification window.
                    if (!lock_s) begin
                        cnt_d = '0;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_d = ST_REL_IC;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                ST_REL_IC: begin
                    if (!lock_s) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                        cause_d = CAUSE_PLL;
                    end else if (cnt_q == GAP_LAST) begin
                        state_d = ST_REL_PERIPH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                ST_REL_PERIPH: begin
                    if (!lock_s) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                        cause_d = CAUSE_PLL;
                    end else if (cnt_q == GAP_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                ST_RUN: begin
                    cnt_d = '0;
                    // Lock loss outranks watchdog, which outranks software.
                    if (!lock_s) begin
                        state_d = ST_HOLD;
                        cause_d = CAUSE_PLL;
                    end else if (i_wdt_expire) begin
                        state_d = ST_HOLD;
                        cause_d = CAUSE_WDT;
                    end else if (i_sw_reset_req) begin
                        state_d = ST_HOLD;
                        cause_d = CAUSE_SW;
                    end
                end

                default: begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            endcase
        end

        // Outputs are decoded from the next state so each release or
        // re-assert appears on the same edge as the state change.
        ic_areset_n_d     = (state_d != ST_HOLD);
        periph_areset_n_d = (state_d == ST_REL_PERIPH) || (state_d == ST_RUN);
        core_reset_d      = (state_d != ST_RUN);
        busy_d            = (state_d != ST_RUN);
    end

    always_ff @(posedge i_aclk or posedge i_reset) begin
        if (i_reset) begin
            state_q           <= ST_HOLD;
            cnt_q             <= '0;
            cause_q           <= CAUSE_EXT;
            ic_areset_n_q     <= 1'b0;
            periph_areset_n_q <= 1'b0;
            core_reset_q      <= 1'b1;
            busy_q            <= 1'b1;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            cause_q           <= cause_d;
            ic_areset_n_q     <= ic_areset_n_d;
            periph_areset_n_q <= periph_areset_n_d;
            core_reset_q      <= core_reset_d;
            busy_q            <= busy_d;
        end
    end

    assign o_ic_areset_n     = ic_areset_n_q;
    assign o_periph_areset_n = periph_areset_n_q;
    assign o_core_reset      = core_reset_q;
    assign o_busy            = busy_q;
    assign o_reset_cause     = cause_q;

endmodule
